// File: rtl/decimal_rx_parser.sv
// Parses CR/LF-terminated ASCII decimal lines from a UART byte stream
// into unsigned binary values, flagging bad characters, overflow and overrun.
module decimal_rx_parser #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             value_ready,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int ACC_W = WIDTH + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'({WIDTH{1'b1}});

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_CHAR = 2'b01;
    localparam logic [1:0] E_OVFL = 2'b10;
    localparam logic [1:0] E_OVRN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD,
        S_SKIP
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             value_valid_q, value_valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             is_digit;
    logic             is_term;
    logic [ACC_W-1:0] digit;
    logic [ACC_W-1:0] acc_mac;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign digit    = ACC_W'(rx_data[3:0]);
    // WIDTH+4 bits hold (2^WIDTH-1)*10+9 without wrapping
    assign acc_mac  = acc_q * ACC_W'(10) + digit;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        value_d       = value_q;
        value_valid_d = value_valid_q;
        err_d         = 1'b0;
        err_code_d    = E_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        acc_d   = digit;
                        cnt_d   = CNT_W'(1);
                        state_d = S_ACCUM;
                    end else if (!is_term) begin
                        err_d      = 1'b1;
                        err_code_d = E_CHAR;
                        state_d    = S_SKIP;
                    end
                end
            end
            S_ACCUM: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (cnt_q == CNT_W'(MAX_DIGITS) || acc_mac > MAX_VAL) begin
                            err_d      = 1'b1;
                            err_code_d = E_OVFL;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = S_SKIP;
                        end else begin
                            acc_d = acc_mac;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        value_d       = acc_q[WIDTH-1:0];
                        value_valid_d = 1'b1;
                        acc_d         = '0;
                        cnt_d         = '0;
                        state_d       = S_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = E_CHAR;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = S_SKIP;
                    end
                end
            end
            S_HOLD: begin
                // a late CR after LF (or vice versa) is not an overrun
                if (rx_valid && !is_term) begin
                    err_d      = 1'b1;
                    err_code_d = E_OVRN;
                end
                if (value_ready) begin
                    value_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            S_SKIP: begin
                if (rx_valid && is_term) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= E_NONE;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_decimal_rx_parser.sv
// Directed bench for decimal_rx_parser; a negedge monitor checks every
// value and err pulse against queues of expected results.
module tb_decimal_rx_parser;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        value_ready;
    logic [15:0] value;
    logic        value_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int exp_val_q[$];
    int exp_err_q[$];
    logic vv_prev = 1'b0;

    decimal_rx_parser #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .value_ready(value_ready),
        .value      (value),
        .value_valid(value_valid),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // scoreboard: pop expectations as the DUT produces results
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) begin
                if (exp_err_q.size() == 0) begin
                    check("unexpected_err", int'(err_code), -1);
                end else begin
                    check("err_code", int'(err_code), exp_err_q.pop_front());
                end
            end
            if (value_valid && !vv_prev) begin
                if (exp_val_q.size() == 0) begin
                    check("unexpected_value", int'(value), -1);
                end else begin
                    check("value", int'(value), exp_val_q.pop_front());
                end
            end
            vv_prev = value_valid;
        end else begin
            vv_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk) #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk) #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic handshake();
        @(posedge clk) #1;
        value_ready = 1'b1;
        @(posedge clk) #1;
        value_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        value_ready = 1'b0;
        #12;
        check("rst_value", int'(value), 0);
        check("rst_vv", int'(value_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // bare terminators: nothing happens
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("empty_busy1", int'(busy), 0);
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("empty_busy2", int'(busy), 0);
        check("empty_vv", int'(value_valid), 0);

        // "123" CR LF
        exp_val_q.push_back(123);
        send_str("123");
        check("accum_busy", int'(busy), 1);
        check("accum_vv", int'(value_valid), 0);
        send_byte(8'h0D);
        check("vv_latency", int'(value_valid), 1);
        send_byte(8'h0A);
        check("hold_after_lf", int'(value_valid), 1);
        handshake();
        check("ack_vv", int'(value_valid), 0);
        check("ack_busy", int'(busy), 0);
        check("ack_value_kept", int'(value), 123);

        // max value, then overflow, then recovery
        exp_val_q.push_back(65535);
        send_str("65535");
        send_byte(8'h0D);
        handshake();
        exp_err_q.push_back(2);
        send_str("65536");
        check("ovf_busy", int'(busy), 1);
        send_byte(8'h0D);
        check("ovf_vv", int'(value_valid), 0);
        check("ovf_idle", int'(busy), 0);
        exp_val_q.push_back(7);
        send_str("7");
        send_byte(8'h0A);
        handshake();

        // bad char mid-line
        exp_err_q.push_back(1);
        send_str("12a4");
        send_byte(8'h0D);
        check("badchar_idle", int'(busy), 0);
        send_byte(8'h0A);
        check("badchar_vv", int'(value_valid), 0);

        // exactly MAX_DIGITS with leading zeros accepted
        exp_val_q.push_back(7);
        send_str("00007");
        send_byte(8'h0D);
        handshake();

        // sixth digit overflows the digit count
        exp_err_q.push_back(2);
        send_str("000007");
        send_byte(8'h0D);
        check("digits_idle", int'(busy), 0);
        check("digits_vv", int'(value_valid), 0);

        // overrun while holding
        exp_val_q.push_back(42);
        send_str("42");
        send_byte(8'h0D);
        exp_err_q.push_back(3);
        send_str("5");
        check("ovrn_value", int'(value), 42);
        check("ovrn_vv", int'(value_valid), 1);
        exp_err_q.push_back(3);
        @(posedge clk) #1;
        rx_valid    = 1'b1;
        rx_data     = "9";
        value_ready = 1'b1;
        @(posedge clk) #1;
        rx_valid    = 1'b0;
        value_ready = 1'b0;
        check("ovrn_ack_vv", int'(value_valid), 0);
        check("ovrn_ack_busy", int'(busy), 0);
        check("ovrn_ack_value", int'(value), 42);

        // reset mid-line
        send_str("12");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_value", int'(value), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_vv", int'(value_valid), 0);
        check("midrst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_val_q.push_back(9);
        send_str("9");
        send_byte(8'h0D);
        handshake();

        repeat (3) @(posedge clk);
        #1;
        check("val_queue_empty", exp_val_q.size(), 0);
        check("err_queue_empty", exp_err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decimal_rx_parser.md
DECIMAL_RX_PARSER -- requirements
Module: decimal_rx_parser

Interface
REQ-001 Parameter: WIDTH, 16, bit width of the parsed result.
REQ-002 Parameter: MAX_DIGITS, 5, maximum decimal digits accepted per line; leading zeros count.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-006 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 value_ready  input  1  consumer accepts value while value_valid=1.
REQ-008 value  output  WIDTH  parsed unsigned decimal number; stable while value_valid=1.
REQ-009 value_valid  output  1  value holds a complete line result; held until value_ready.
REQ-010 err  output  1  one-cycle pulse on a parse error or overrun.
REQ-011 err_code  output  2  error class, valid with err: 01 bad char, 10 overflow, 11 overrun; 00 otherwise.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The module SHALL parse ASCII lines of decimal digits ('0'=0x30..'9'=0x39) terminated by CR (0x0D) or LF (0x0A) into an unsigned binary value.
REQ-014 States SHALL be IDLE, ACCUM, HOLD, SKIP; rx bytes are evaluated only in cycles with rx_valid=1.
REQ-015 IDLE: digit -> acc=digit, digit count=1, go ACCUM; CR/LF -> ignored, stay IDLE; any other byte -> err pulse code 01, go SKIP.
REQ-016 ACCUM: digit with count<MAX_DIGITS and acc*10+digit <= 2^WIDTH-1 -> acc updated, count+1, stay ACCUM.
REQ-017 ACCUM: digit with count==MAX_DIGITS or acc*10+digit > 2^WIDTH-1 -> err pulse code 10, go SKIP; acc discarded.
REQ-018 ACCUM: CR/LF -> value<=acc, value_valid<=1, go HOLD; latency: value_valid high on the edge after the terminator's rx_valid cycle.
REQ-019 ACCUM: any other byte -> err pulse code 01, go SKIP.
REQ-020 HOLD: value_valid=1; value_ready=1 -> value_valid cleared next edge, go IDLE; value retains last result after clear.
REQ-021 HOLD: incoming CR/LF silently dropped (covers CR LF pairs); any other byte dropped with err pulse code 11; value unchanged.
REQ-022 HOLD with rx_valid and value_ready in the same cycle: byte handled per REQ-021, then transition to IDLE.
REQ-023 SKIP: all bytes discarded without further err; CR/LF -> go IDLE (terminator consumed, produces no value).
REQ-024 Overflow check SHALL use an internal accumulator of at least WIDTH+4 bits; no truncation of the product before comparison.
REQ-025 err SHALL be high for exactly one cycle per offending byte; at most one err per rx_valid strobe.
REQ-026 busy SHALL be high in ACCUM, HOLD and SKIP.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, acc=0, digit count=0, value=0, value_valid=0, err=0, err_code=00, busy=0.
REQ-028 Reset mid-line SHALL discard partial digits; the first line after reset parses from empty.

Verification
REQ-029 Bytes "123" CR LF -> value=123, value_valid high one cycle after CR; LF in HOLD gives no err; ready pulse -> value_valid low, busy low.
REQ-030 "65535" CR -> value=65535; then "65536" CR -> err code 10 on the final '6', no value_valid; then "7" LF -> value=7.
REQ-031 "12a4" CR LF -> err code 01 on 'a' only, no value_valid, state IDLE after CR; "000007" CR (MAX_DIGITS=5) -> err code 10 on sixth digit.
REQ-032 "42" CR, value_ready held low, send "5" -> err code 11, value stays 42; raise ready same cycle as next byte "9" -> err 11, then IDLE.
REQ-033 "12", assert rst_n low for 2 cycles mid-line -> all outputs 0; then "9" CR -> value=9 (not 129).
REQ-034 CR LF CR LF with no digits -> no value_valid, no err, busy stays low.
